// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving an external Montgomery multiplier.
// Latency: 2 + per-bit (square, plus multiply on set bits) multiplier round trips; waits on mul_done indefinitely.
module mont_exp_ctrl (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic [511:0] in_x,
    input  logic [511:0] in_e,
    input  logic [511:0] in_m,
    input  logic [511:0] in_r,
    input  logic [9:0]   exp_len,
    output logic         mul_start,
    output logic [511:0] mul_a,
    output logic [511:0] mul_b,
    output logic [511:0] mul_m,
    input  logic [511:0] mul_result,
    input  logic         mul_done,
    output logic [511:0] result,
    output logic         done,
    output logic         busy
);

    typedef enum logic [2:0] {
        IDLE, LOAD, SQ_ISSUE, SQ_WAIT, MUL_ISSUE, MUL_WAIT, NEXT, DONE
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [511:0] acc;
    logic [511:0] x_q;
    logic [511:0] e_q;
    logic [511:0] m_q;
    logic [8:0]   idx;
    logic [9:0]   len;
    logic [8:0]   idx_init;

    assign len      = (exp_len > 10'd512) ? 10'd512 : exp_len;
    // len=512 wraps to 0 in 9 bits, so the decrement lands on 511 as required
    assign idx_init = len[8:0] - 9'd1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mul_start = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE:      if (start) state_nxt = LOAD;
            LOAD:      state_nxt = (len == 10'd0) ? DONE : SQ_ISSUE;
            SQ_ISSUE: begin
                mul_start = 1'b1;
                state_nxt = SQ_WAIT;
            end
            SQ_WAIT:   if (mul_done) state_nxt = e_q[idx] ? MUL_ISSUE : NEXT;
            MUL_ISSUE: begin
                mul_start = 1'b1;
                state_nxt = MUL_WAIT;
            end
            MUL_WAIT:  if (mul_done) state_nxt = NEXT;
            NEXT:      state_nxt = (idx == 9'd0) ? DONE : SQ_ISSUE;
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc    <= '0;
            x_q    <= '0;
            e_q    <= '0;
            m_q    <= '0;
            idx    <= '0;
            result <= '0;
        end else begin
            case (state)
                LOAD: begin
                    x_q <= in_x;
                    e_q <= in_e;
                    m_q <= in_m;
                    acc <= in_r;
                    idx <= idx_init;
                    if (len == 10'd0) result <= in_r;
                end
                SQ_WAIT, MUL_WAIT: if (mul_done) acc <= mul_result;
                NEXT: begin
                    if (idx == 9'd0) result <= acc;
                    else             idx    <= idx - 9'd1;
                end
                default: ;
            endcase
        end
    end

    // acc only moves on mul_done, so operands stay frozen for the whole wait
    assign mul_a = acc;
    assign mul_b = (state == MUL_ISSUE || state == MUL_WAIT) ? x_q : acc;
    assign mul_m = m_q;
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Directed bench for mont_exp_ctrl with a latency-4 bit-serial Montgomery multiplier model.
module tb_mont_exp_ctrl;

    logic         clk = 1'b0;
    logic         resetn;
    logic         start;
    logic [511:0] in_x, in_e, in_m, in_r;
    logic [9:0]   exp_len;
    logic         mul_start;
    logic [511:0] mul_a, mul_b, mul_m, mul_result, result;
    logic         mul_done, done, busy;

    logic         mdl_done = 1'b0;
    logic         inj_done = 1'b0;
    logic [511:0] mdl_res  = '0;
    assign mul_done   = mdl_done | inj_done;
    assign mul_result = mdl_res;

    always #5 clk = ~clk;

    mont_exp_ctrl dut (
        .clk(clk), .resetn(resetn), .start(start),
        .in_x(in_x), .in_e(in_e), .in_m(in_m), .in_r(in_r), .exp_len(exp_len),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_m(mul_m),
        .mul_result(mul_result), .mul_done(mul_done),
        .result(result), .done(done), .busy(busy)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Montgomery product a*b*2^-512 mod m, computed bit-serially
    function automatic logic [511:0] mont(input logic [511:0] a, input logic [511:0] b,
                                          input logic [511:0] m);
        logic [513:0] t;
        t = '0;
        for (int i = 0; i < 512; i++) begin
            if (a[i]) t = t + {2'b00, b};
            if (t[0]) t = t + {2'b00, m};
            t = t >> 1;
        end
        if (t >= {2'b00, m}) t = t - {2'b00, m};
        return t[511:0];
    endfunction

    int           cnt = 0;
    bit           hold = 1'b0;
    int           n_start = 0;
    int           overlap = 0;
    bit           kind_log [0:4095];
    logic [511:0] a_q, b_q, m_q;

    always @(negedge clk) begin
        mdl_done = 1'b0;
        if (cnt > 0) begin
            if (!hold) cnt--;
            if (cnt == 0) begin
                mdl_done = 1'b1;
                mdl_res  = mont(a_q, b_q, m_q);
            end
        end
        if (mul_start) begin
            if (cnt > 0) overlap++;
            a_q = mul_a;
            b_q = mul_b;
            m_q = mul_m;
            cnt = 4;
            kind_log[n_start & 4095] = (mul_a != mul_b);
            n_start++;
        end
    end

    typedef struct {
        logic [9:0]   len;
        logic [511:0] e;
        logic [511:0] x;
        logic [511:0] m;
        int           pulses;
        int           kinds;
        logic [511:0] res;
    } vec_t;

    vec_t vecs [7];

    task automatic wait_done(input int budget);
        int cyc;
        cyc = 0;
        while (!done && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("done_seen", done, 1'b1);
    endtask

    task automatic run(input logic [9:0] len, input logic [511:0] e, input logic [511:0] x,
                       input logic [511:0] m, input logic [511:0] r,
                       output logic [511:0] res, output int pulses, output int kinds);
        int base;
        base = n_start;
        exp_len = len; in_e = e; in_x = x; in_m = m; in_r = r; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 16; k++) begin
            in_x[k*32 +: 32] = $urandom();
            in_e[k*32 +: 32] = $urandom();
            in_m[k*32 +: 32] = $urandom();
            in_r[k*32 +: 32] = $urandom();
        end
        exp_len = 10'($urandom_range(0, 1023));
        wait_done(20000);
        res    = result;
        pulses = n_start - base;
        kinds  = 0;
        for (int i = 0; i < pulses && i < 32; i++)
            if (kind_log[(base + i) & 4095]) kinds |= (1 << i);
        @(posedge clk); #1;
        chk("done_one_cycle", done, 1'b0);
        chk("idle_after_done", busy, 1'b0);
    endtask

    initial begin
        logic [511:0] res, a0, b0, m0;
        int pulses, kinds, base, nb, ns, nu, nd, cyc;

        vecs[0] = '{10'd3, 512'h5,    512'd2,  512'd255, 5,  'h12,  512'd32};
        vecs[1] = '{10'd4, 512'hF,    512'd3,  512'd255, 8,  'hAA,  512'd57};
        vecs[2] = '{10'd8, 512'h81,   512'd7,  512'd255, 10, 'h202, 512'd7};
        vecs[3] = '{10'd3, 512'hFF05, 512'd2,  512'd255, 5,  'h12,  512'd32};
        vecs[4] = '{10'd2, 512'h2,    512'd10, 512'd257, 3,  'h2,   512'd100};
        vecs[5] = '{10'd1, 512'h3,    512'd5,  512'd255, 2,  'h2,   512'd5};
        vecs[6] = '{10'd5, 512'h0,    512'd9,  512'd255, 5,  'h0,   512'd1};

        resetn = 1'b0; start = 1'b0; exp_len = '0;
        in_x = '0; in_e = '0; in_m = '0; in_r = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_mul_start", mul_start, 1'b0);
        chk("rst_result", result, '0);
        chk("rst_mul_a", mul_a, '0);
        chk("rst_mul_m", mul_m, '0);

        // zero-length exponent straight out of reset: IDLE, LOAD, DONE
        base = n_start;
        @(negedge clk);
        resetn = 1'b1; in_r = 512'h5; in_m = 512'd255; exp_len = 10'd0; start = 1'b1;
        @(posedge clk); #1;
        chk("len0_busy_first_edge", busy, 1'b1);
        chk("len0_no_early_done", done, 1'b0);
        start = 1'b0;
        @(posedge clk); #1;
        chk("len0_done_cycle3", done, 1'b1);
        chk("len0_result", result, 512'h5);
        @(posedge clk); #1;
        chk("len0_done_pulse", done, 1'b0);
        chk("len0_idle", busy, 1'b0);
        in_r = 512'h77;
        repeat (5) @(posedge clk);
        #1;
        chk("len0_result_hold", result, 512'h5);
        chk("len0_no_mul_start", n_start - base, 0);

        foreach (vecs[i]) begin
            run(vecs[i].len, vecs[i].e, vecs[i].x, vecs[i].m, 512'd1, res, pulses, kinds);
            chk($sformatf("vec%0d_result", i), res, vecs[i].res);
            chk($sformatf("vec%0d_pulses", i), pulses, vecs[i].pulses);
            chk($sformatf("vec%0d_order", i), kinds, vecs[i].kinds);
        end

        // exp_len above 512 clamps; 2 has order 8 mod 255 so 2^(2^512-1) = 2^7
        run(10'd600, '1, 512'd2, 512'd255, 512'd1, res, pulses, kinds);
        chk("len600_result", res, 512'd128);
        chk("len600_pulses", pulses, 1024);

        // start held high through a run: no restart until back in IDLE
        base = n_start; nb = 0;
        exp_len = 10'd1; in_e = 512'h1; in_x = 512'd3; in_m = 512'd255; in_r = 512'd1;
        start = 1'b1;
        @(posedge clk); #1;
        cyc = 0;
        while (!done && cyc < 200) begin
            if (!busy) nb++;
            @(posedge clk); #1;
            cyc++;
        end
        chk("held_run1_done", done, 1'b1);
        chk("held_run1_result", result, 512'd3);
        chk("held_run1_pulses", n_start - base, 2);
        chk("held_busy_gaps", nb, 0);
        @(posedge clk); #1;
        chk("held_back_to_idle", busy, 1'b0);
        @(posedge clk); #1;
        chk("held_restart_from_idle", busy, 1'b1);
        start = 1'b0;
        wait_done(200);
        chk("held_run2_pulses", n_start - base, 4);
        @(posedge clk); #1;
        inj_done = 1'b1;
        @(posedge clk); #1;
        inj_done = 1'b0;
        nb = 0; ns = 0; nd = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (busy) nb++;
            if (mul_start) ns++;
            if (done) nd++;
        end
        chk("spurious_busy", nb, 0);
        chk("spurious_mul_start", ns, 0);
        chk("spurious_done", nd, 0);
        chk("spurious_result", result, 512'd3);

        // multiplier stalls for 1000 cycles
        hold = 1'b1; base = n_start; nb = 0; ns = 0; nu = 0;
        exp_len = 10'd3; in_e = 512'h5; in_x = 512'd2; in_m = 512'd255; in_r = 512'd1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (!mul_start && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("stall_first_issue", mul_start, 1'b1);
        @(posedge clk); #1;
        a0 = mul_a; b0 = mul_b; m0 = mul_m;
        repeat (1000) begin
            @(posedge clk); #1;
            if (!busy) nb++;
            if (mul_start) ns++;
            if (mul_a !== a0 || mul_b !== b0 || mul_m !== m0) nu++;
        end
        chk("stall_busy", nb, 0);
        chk("stall_no_issue", ns, 0);
        chk("stall_operands_stable", nu, 0);
        chk("stall_operand_m", m0, 512'd255);
        hold = 1'b0;
        wait_done(200);
        chk("stall_result", result, 512'd32);
        chk("stall_pulses", n_start - base, 5);
        @(posedge clk); #1;

        // reset during SQ_WAIT, multiplier answers afterwards
        base = n_start; nb = 0; ns = 0; nd = 0;
        exp_len = 10'd3; in_e = 512'h5; in_x = 512'd2; in_m = 512'd255; in_r = 512'd1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (!mul_start && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        @(posedge clk); #2;
        resetn = 1'b0;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_mul_start", mul_start, 1'b0);
        chk("abort_result", result, '0);
        chk("abort_mul_a", mul_a, '0);
        chk("abort_mul_b", mul_b, '0);
        chk("abort_mul_m", mul_m, '0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (busy) nb++;
            if (mul_start) ns++;
            if (done) nd++;
        end
        chk("late_done_busy", nb, 0);
        chk("late_done_mul_start", ns, 0);
        chk("late_done_done", nd, 0);
        chk("late_done_result", result, '0);
        chk("abort_pulses", n_start - base, 1);

        chk("no_overlapping_mul_start", overlap, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
